// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - iterative AES-128/256 decryption core, one inverse round per clock
//
// aes_inv_sbox
//   Purpose: combinational inverse S-box over one 32-bit column (four bytes).
//   Ports:   data_i [31:0] column in, data_o [31:0] InvSubBytes of each byte.
//
// aes_inv_cipher
//   Purpose: iterative AES decryption, AES-128 (Nr=10) or AES-256 (Nr=14) per block.
//   Ports:   clk_i, rst_i (sync, active-high)
//            in_valid_i / in_ready_o / in_data_i [127:0]   ciphertext in, [127:120]=byte0
//            keylen_i                                      0=AES-128, 1=AES-256, latched at accept
//            rk_idx_o [3:0] / rk_i [127:0]                 round-key request, key returned same cycle
//            out_valid_o / out_ready_i / out_data_o [127:0] plaintext out
//            busy_o                                        high while a block is in flight

module aes_inv_sbox (
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; it also maps 0 to 0, as the S-box needs.
  // Each loop step turns a^(2^k-1) into a^(2^(k+1)-1), ending at a^127.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    t = a;
    for (int i = 0; i < 6; i++) begin
      t = gf_mul(gf_mul(t, t), a);
    end
    return gf_mul(t, t);
  endfunction

  // Inverse affine transform first, then field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(s);
  endfunction

  assign data_o = {inv_sbox(data_i[31:24]), inv_sbox(data_i[23:16]),
                   inv_sbox(data_i[15:8]),  inv_sbox(data_i[7:0])};

endmodule

module aes_inv_cipher #(
  parameter bit KEY256_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  input  logic         keylen_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [127:0] out_data_q;
  logic [3:0]   ctr_q;
  logic         out_valid_q;

  logic         keylen_eff;
  logic [3:0]   nr_in;
  logic [127:0] isr;         // InvShiftRows(state_q)
  logic [127:0] isb;         // InvSubBytes(isr)
  logic [127:0] out_data_d;  // final-round result (no InvMixColumns)
  logic [127:0] state_d;     // middle-round result

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column multiply by the {0e,0b,0d,09} circulant using only xtime chains.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a;
    logic [3:0][7:0] m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    a = col;
    for (int i = 0; i < 4; i++) begin
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    // a[3] is byte row 0 of the column (packed MSB first).
    return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
            m9[3] ^ me[2] ^ mb[1] ^ md[0],
            md[3] ^ m9[2] ^ me[1] ^ mb[0],
            mb[3] ^ md[2] ^ m9[1] ^ me[0]};
  endfunction

  assign keylen_eff = KEY256_EN ? keylen_i : 1'b0;
  assign nr_in      = keylen_eff ? 4'd14 : 4'd10;

  // Byte (col c, row r) lives at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .data_i (isr[127-32*g -: 32]),
      .data_o (isb[127-32*g -: 32])
    );
  end

  assign out_data_d = isb ^ rk_i;

  always_comb begin
    state_d = '0;
    for (int c = 0; c < 4; c++) begin
      state_d[127-32*c -: 32] = inv_mix_col(out_data_d[127-32*c -: 32]);
    end
  end

  always_comb begin
    case (fsm_q)
      IDLE:    rk_idx_o = nr_in;
      ROUND:   rk_idx_o = ctr_q;
      default: rk_idx_o = 4'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      out_data_q  <= '0;
      ctr_q       <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q <= in_data_i ^ rk_i;
            ctr_q   <= nr_in - 4'd1;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          if (ctr_q != 4'd0) begin
            state_q <= state_d;
            ctr_q   <= ctr_q - 4'd1;
          end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (fsm_q == IDLE);
  assign busy_o      = (fsm_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb/tb_aes_inv_cipher.sv - directed known-answer bench for aes_inv_cipher
module tb_aes_inv_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, keylen, out_valid, out_ready, busy;
  logic [127:0] in_data, rk, out_data;
  logic [3:0]   rk_idx;
  logic         in_valid_n, in_ready_n, out_valid_n, busy_n;
  logic [127:0] rk_n, out_data_n;
  logic [3:0]   rk_idx_n;

  logic [127:0] rk_mem [16];
  logic [127:0] rk128_mem [16];
  logic [7:0]   sbox [256];

  int checks = 0;
  int failures = 0;

  assign rk   = rk_mem[rk_idx];
  assign rk_n = rk128_mem[rk_idx_n];

  aes_inv_cipher #(.KEY256_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .keylen_i(keylen), .rk_idx_o(rk_idx), .rk_i(rk),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy)
  );

  aes_inv_cipher #(.KEY256_EN(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_n), .in_ready_o(in_ready_n),
    .in_data_i(in_data), .keylen_i(1'b1), .rk_idx_o(rk_idx_n), .rk_i(rk_n),
    .out_valid_o(out_valid_n), .out_ready_i(out_ready), .out_data_o(out_data_n), .busy_o(busy_n)
  );

  typedef struct {
    logic         kl;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    string        name;
  } vec_t;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box: inverse found by exhaustive search, then the forward affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nw;
    nk = kl ? 8 : 4;
    nw = kl ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r < nw / 4) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else            rk_mem[r] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Accepts one block and runs it to out_valid; leaves the core in DONE.
  task automatic run_block(input logic kl, input logic [127:0] ct, input logic [127:0] pt,
                           input string name);
    int  nr, n;
    bit  seq_ok;
    nr = kl ? 14 : 10;
    n  = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    keylen = kl;
    #1;
    check({name, "_ready"}, 128'(in_ready), 128'd1);
    check({name, "_idle_idx"}, 128'(rk_idx), 128'(nr));
    in_data  = ct;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    keylen   = ~kl;
    n        = 0;
    seq_ok   = 1'b1;
    while (!out_valid && n < 40) begin
      if (int'(rk_idx) != nr - 1 - n) seq_ok = 1'b0;
      step();
      n++;
    end
    check({name, "_latency"}, 128'(n), 128'(nr));
    check({name, "_idx_seq"}, 128'(seq_ok), 128'd1);
    check({name, "_pt"}, out_data, pt);
    check({name, "_done_idx"}, 128'(rk_idx), 128'd0);
  endtask

  vec_t vecs [3];

  initial begin
    logic [127:0] held;
    int           acc_cyc [$];
    logic [127:0] outs [$];
    int           n;
    bit           ok;

    vecs[0] = '{kl: 1'b0, key: KEY128, ct: CT1, pt: PT1, name: "t1_aes128"};
    vecs[1] = '{kl: 1'b1, key: KEY256, ct: 128'h8ea2b7ca516745bfeafc49904b496089, pt: PT1,
                name: "t2_aes256"};
    vecs[2] = '{kl: 1'b0, key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734, name: "fips_b"};

    rst = 1'b1; in_valid = 1'b0; in_valid_n = 1'b0; in_data = '0; keylen = 1'b0; out_ready = 1'b0;
    build_sbox();
    expand_key(KEY128, 1'b0);
    for (int i = 0; i < 16; i++) rk128_mem[i] = rk_mem[i];

    step();
    step();
    check("rst_ready", 128'(in_ready), 128'd1);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_data", out_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_idx", 128'(rk_idx), 128'd10);
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      expand_key(vecs[i].key, vecs[i].kl);
      run_block(vecs[i].kl, vecs[i].ct, vecs[i].pt, vecs[i].name);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({vecs[i].name, "_idle_after"}, 128'(in_ready && !out_valid), 128'd1);
    end

    // Back-pressure: 20 stalled DONE cycles with stray in_valid pulses.
    expand_key(KEY128, 1'b0);
    run_block(1'b0, CT1, PT1, "t3_bp");
    held = out_data;
    ok   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (!out_valid || in_ready || out_data !== held) ok = 1'b0;
    end
    check("t3_stable", 128'(ok), 128'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_release", 128'({in_ready, out_valid}), 128'b10);
    step();
    step();
    check("t3_no_accept", 128'(busy), 128'd0);

    // Back-to-back with in_valid and out_ready held high.
    in_data   = CT1;
    keylen    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (in_valid && in_ready) acc_cyc.push_back(c);
      if (out_valid && out_ready) outs.push_back(out_data);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t4_accepts", 128'(acc_cyc.size()), 128'd2);
    if (acc_cyc.size() == 2) check("t4_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    check("t4_outputs", 128'(outs.size()), 128'd2);
    for (int i = 0; i < outs.size(); i++) check("t4_pt", outs[i], PT1);
    step();
    check("t4_idle", 128'(busy), 128'd0);

    // Reset in round 5 drops the block.
    in_data  = CT1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("t5_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_after_rst", 128'({out_valid, in_ready, busy}), 128'b010);
    check("t5_data_clr", out_data, 128'd0);
    run_block(1'b0, CT1, PT1, "t5_fresh");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // KEY256_EN=0 instance with keylen_i tied high behaves as AES-128.
    in_data = CT1;
    #1;
    check("t6_ready", 128'(in_ready_n), 128'd1);
    check("t6_idle_idx", 128'(rk_idx_n), 128'd10);
    in_valid_n = 1'b1;
    step();
    in_valid_n = 1'b0;
    n = 0;
    while (!out_valid_n && n < 40) begin
      step();
      n++;
    end
    check("t6_latency", 128'(n), 128'd10);
    check("t6_pt", out_data_n, PT1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t6_idle_after", 128'(in_ready_n), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
